caf_foas_ctrl: RTL and testbench
================================

# caf_foas_ctrl

Parametrised frequency-offset (FOAS) controller and cross-slice peak reducer for the CAF engine. It loads one frequency step and one shift sign per slice over an AXI-stream port, runs the `caf_slice` bank, and captures each slice's peak. It then reduces the peaks to a single (magnitude, time index, frequency index, detect) result on an AXI-stream output. Added over the previous CAF top: synchronous reset, per-slice held `neg_shift`, completed FIND_MAX/RETURN_MAX, threshold detect, and steady-state re-runs without reloading.

## Interface
- `phase_bits`, 10, frequency step width
- `foas`, 4, number of slices (>=1)
- `foas_counter_bits`, 2, slice index width (2^foas_counter_bits >= foas)
- `length_counter_bits`, 3, slice time-index width
- `out_max_bits`, 64, peak magnitude width (unsigned)

Ports:
- `clk` in 1, single clock
- `rst` in 1, reset, synchronous, active-high
- `s_axis_freq_step_tvalid` in 1, load beat valid
- `s_axis_freq_step_tready` out 1, load beat ready
- `freq_step` in phase_bits, step for current slice
- `neg_shift` in 1, shift sign for current slice
- `reload` in 1, pulse; request new step set after current result
- `threshold` in out_max_bits, detect threshold
- `slice_freq_step` out phase_bits, step broadcast to slices
- `slice_freq_step_valid` out foas, one-hot load strobe
- `slice_neg_shift` out foas, held per-slice sign
- `slice_run` out 1, drives slice m_axis_tready
- `slice_valid` in foas, per-slice result valid
- `slice_out_max` in foas*out_max_bits, packed peaks, slice i at [i*out_max_bits +: out_max_bits]
- `slice_index` in foas*length_counter_bits, packed time indices
- `m_axis_tvalid` out 1, result valid
- `m_axis_tready` in 1, result ready
- `m_axis_max` out out_max_bits, best peak
- `m_axis_time_index` out length_counter_bits, time index of best
- `m_axis_freq_index` out foas_counter_bits, slice index of best
- `m_axis_detect` out 1, best >= threshold

## Operation
- States: LOAD, CORRELATE, FIND_MAX, RETURN_MAX. Reset state is LOAD.
- Reset values:
  - every output 0, except `s_axis_freq_step_tready`=1 (LOAD);
  - load counter 0, capture vector 0, reload flag 0.
- LOAD:
  - `s_axis_freq_step_tready`=1.
  - Beat accepted (tvalid&tready) with counter k:
    - `slice_freq_step`<=freq_step;
    - `slice_freq_step_valid`<=1<<k for exactly one cycle;
    - `slice_neg_shift[k]`<=neg_shift (other bits held);
    - k++.
  - No beat: strobe 0, counter holds.
  - Beat with k==foas-1 → CORRELATE; tready falls the same edge.
- CORRELATE:
  - `slice_run`=1.
  - Each cycle, for each i with `slice_valid[i]`=1 and capture bit i clear: latch slice_out_max/slice_index for i and set capture bit i (first valid wins).
  - Capture vector all ones → FIND_MAX; `slice_run`=0 from that edge.
- FIND_MAX:
  - Sample `threshold` on entry.
  - Scan i=0..foas-1, one slice per cycle.
  - i=0 initialises best. For i>0, update only if cap_max[i] > best (strict unsigned), so the lowest index wins ties.
- RETURN_MAX:
  - `m_axis_tvalid`=1; `m_axis_*` are stable until `m_axis_tready`.
  - `m_axis_detect` = best >= sampled threshold.
  - On handshake: tvalid<=0, capture cleared.
    - Reload flag set → LOAD, counter 0, flag cleared.
    - Otherwise → CORRELATE with the same steps.
- `reload`:
  - sets the sticky flag in CORRELATE, FIND_MAX or RETURN_MAX;
  - ignored in LOAD.
- Inputs outside their state are ignored: `slice_valid` outside CORRELATE, freq-step beats outside LOAD.
- `rst` wins over every event at the same edge. Mid-operation reset returns to the reset values next cycle, including a pending result (dropped) and `slice_neg_shift` (cleared).

## Timing
- Load strobe appears 1 cycle after the accepting edge.
- LOAD lasts at least foas cycles (back-to-back beats).
- CORRELATE exits on the edge after the last capture bit sets.
- FIND_MAX lasts exactly foas cycles.
- `m_axis_tvalid` rises on the first RETURN_MAX cycle, i.e. foas+1 cycles after the final capture.
- Handshake with tready held high: RETURN_MAX lasts 1 cycle.
- foas=1: single-beat LOAD and 1-cycle FIND_MAX; `m_axis_freq_index`=0.
- Load counter never wraps: it is cleared on leaving LOAD.

## Test plan
- Common setup: foas=4, out_max_bits=16.
- Load and strobes: reset, then 4 back-to-back beats with steps 10, 20, 30, 40 and neg_shift 0, 1, 0, 1.
  - `slice_freq_step_valid`=0001, 0010, 0100, 1000 on consecutive cycles.
  - `slice_neg_shift`=1010 after load.
  - tready=0 in CORRELATE.
- Load stall: tvalid gap of 3 cycles after beat 2 → counter holds, no strobe during the gap, loading resumes with slice 2.
- Reduction with tie:
  - slice peaks 100/500/500/200, indices 1/2/5/7 delivered in order 3,0,2,1, threshold 400.
  - Expected result: max=500, time=2, freq=1, detect=1.
  - tvalid rises exactly 5 cycles after the last valid.
- Backpressure and rerun:
  - tready low for 6 cycles → outputs stable.
  - After handshake: state CORRELATE, slice_run=1, no load strobes.
  - Threshold 600 on next run → detect=0.
- Reload and reset:
  - reload pulsed during FIND_MAX → after handshake, tready=1 and a fresh load is required.
  - `rst` mid-CORRELATE → next cycle all outputs 0, state LOAD, `slice_neg_shift`=0000.

Source files
------------

// File: rtl/caf_foas_ctrl.sv
// FOAS controller for the CAF slice bank: loads per-slice frequency steps, runs the
// slices, captures each slice peak and reduces them to one AXI-stream result.
module caf_foas_ctrl #(
  parameter int unsigned phase_bits          = 10,
  parameter int unsigned foas                = 4,
  parameter int unsigned foas_counter_bits   = 2,
  parameter int unsigned length_counter_bits = 3,
  parameter int unsigned out_max_bits        = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_axis_freq_step_tvalid,
  output logic                                  s_axis_freq_step_tready,
  input  logic [phase_bits-1:0]                 freq_step,
  input  logic                                  neg_shift,
  input  logic                                  reload,
  input  logic [out_max_bits-1:0]               threshold,
  output logic [phase_bits-1:0]                 slice_freq_step,
  output logic [foas-1:0]                       slice_freq_step_valid,
  output logic [foas-1:0]                       slice_neg_shift,
  output logic                                  slice_run,
  input  logic [foas-1:0]                       slice_valid,
  input  logic [foas*out_max_bits-1:0]          slice_out_max,
  input  logic [foas*length_counter_bits-1:0]   slice_index,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [out_max_bits-1:0]               m_axis_max,
  output logic [length_counter_bits-1:0]        m_axis_time_index,
  output logic [foas_counter_bits-1:0]          m_axis_freq_index,
  output logic                                  m_axis_detect
);

  localparam int unsigned PW = phase_bits;
  localparam int unsigned NS = foas;
  localparam int unsigned CW = foas_counter_bits;
  localparam int unsigned LW = length_counter_bits;
  localparam int unsigned MW = out_max_bits;

  typedef enum logic [1:0] {LOAD, CORRELATE, FIND_MAX, RETURN_MAX} state_t;

  state_t          state_q, state_d;
  logic            tready_q, tready_d;
  logic            run_q, run_d;
  logic            tvalid_q, tvalid_d;
  logic [PW-1:0]   step_q, step_d;
  logic [NS-1:0]   strobe_q, strobe_d;
  logic [NS-1:0]   neg_q, neg_d;
  logic [CW-1:0]   ld_cnt_q, ld_cnt_d;
  logic [NS-1:0]   cap_q, cap_d;
  logic [MW-1:0]   cap_max_q [NS];
  logic [MW-1:0]   cap_max_d [NS];
  logic [LW-1:0]   cap_idx_q [NS];
  logic [LW-1:0]   cap_idx_d [NS];
  logic [MW-1:0]   thr_q, thr_d;
  logic [CW-1:0]   scan_q, scan_d;
  logic [MW-1:0]   best_max_q, best_max_d;
  logic [LW-1:0]   best_time_q, best_time_d;
  logic [CW-1:0]   best_freq_q, best_freq_d;
  logic [MW-1:0]   m_max_q, m_max_d;
  logic [LW-1:0]   m_time_q, m_time_d;
  logic [CW-1:0]   m_freq_q, m_freq_d;
  logic            m_det_q, m_det_d;
  logic            reload_q, reload_d;

  logic            accept;
  logic            load_last;
  logic            cap_full;
  logic            scan_last;
  logic            out_hs;
  logic            take;
  logic [MW-1:0]   nx_max;
  logic [LW-1:0]   nx_time;
  logic [CW-1:0]   nx_freq;

  assign accept    = s_axis_freq_step_tvalid & tready_q & (state_q == LOAD);
  assign load_last = accept & (ld_cnt_q == CW'(NS - 1));
  assign cap_full  = &cap_q;
  assign scan_last = (scan_q == CW'(NS - 1));
  assign out_hs    = tvalid_q & m_axis_tready;

  // Running maximum; strict compare keeps the lowest slice index on ties.
  assign take    = (scan_q == '0) || (cap_max_q[scan_q] > best_max_q);
  assign nx_max  = take ? cap_max_q[scan_q] : best_max_q;
  assign nx_time = take ? cap_idx_q[scan_q] : best_time_q;
  assign nx_freq = take ? scan_q : best_freq_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:       if (load_last) state_d = CORRELATE;
      CORRELATE:  if (cap_full)  state_d = FIND_MAX;
      FIND_MAX:   if (scan_last) state_d = RETURN_MAX;
      RETURN_MAX: if (out_hs)    state_d = (reload_q | reload) ? LOAD : CORRELATE;
      default:                   state_d = LOAD;
    endcase
  end

  always_comb begin
    tready_d    = (state_d == LOAD);
    run_d       = (state_d == CORRELATE);
    tvalid_d    = (state_d == RETURN_MAX);
    step_d      = step_q;
    strobe_d    = '0;
    neg_d       = neg_q;
    ld_cnt_d    = ld_cnt_q;
    cap_d       = cap_q;
    cap_max_d   = cap_max_q;
    cap_idx_d   = cap_idx_q;
    thr_d       = thr_q;
    scan_d      = scan_q;
    best_max_d  = best_max_q;
    best_time_d = best_time_q;
    best_freq_d = best_freq_q;
    m_max_d     = m_max_q;
    m_time_d    = m_time_q;
    m_freq_d    = m_freq_q;
    m_det_d     = m_det_q;
    reload_d    = reload_q;

    if (reload && (state_q != LOAD)) reload_d = 1'b1;

    case (state_q)
      LOAD: begin
        if (accept) begin
          step_d   = freq_step;
          ld_cnt_d = load_last ? '0 : ld_cnt_q + CW'(1);
          for (int i = 0; i < NS; i++) begin
            if (ld_cnt_q == CW'(i)) begin
              strobe_d[i] = 1'b1;
              neg_d[i]    = neg_shift;
            end
          end
        end
      end
      CORRELATE: begin
        // First valid per slice wins; later beats from a captured slice are dropped.
        for (int i = 0; i < NS; i++) begin
          if (slice_valid[i] && !cap_q[i]) begin
            cap_d[i]     = 1'b1;
            cap_max_d[i] = slice_out_max[i*MW +: MW];
            cap_idx_d[i] = slice_index[i*LW +: LW];
          end
        end
        if (cap_full) begin
          thr_d  = threshold;
          scan_d = '0;
        end
      end
      FIND_MAX: begin
        best_max_d  = nx_max;
        best_time_d = nx_time;
        best_freq_d = nx_freq;
        scan_d      = scan_last ? '0 : scan_q + CW'(1);
        if (scan_last) begin
          m_max_d  = nx_max;
          m_time_d = nx_time;
          m_freq_d = nx_freq;
          m_det_d  = (nx_max >= thr_q);
        end
      end
      RETURN_MAX: begin
        if (out_hs) begin
          cap_d    = '0;
          reload_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tready_q    <= 1'b1;
      run_q       <= 1'b0;
      tvalid_q    <= 1'b0;
      step_q      <= '0;
      strobe_q    <= '0;
      neg_q       <= '0;
      ld_cnt_q    <= '0;
      cap_q       <= '0;
      cap_max_q   <= '{default: '0};
      cap_idx_q   <= '{default: '0};
      thr_q       <= '0;
      scan_q      <= '0;
      best_max_q  <= '0;
      best_time_q <= '0;
      best_freq_q <= '0;
      m_max_q     <= '0;
      m_time_q    <= '0;
      m_freq_q    <= '0;
      m_det_q     <= 1'b0;
      reload_q    <= 1'b0;
    end else begin
      tready_q    <= tready_d;
      run_q       <= run_d;
      tvalid_q    <= tvalid_d;
      step_q      <= step_d;
      strobe_q    <= strobe_d;
      neg_q       <= neg_d;
      ld_cnt_q    <= ld_cnt_d;
      cap_q       <= cap_d;
      cap_max_q   <= cap_max_d;
      cap_idx_q   <= cap_idx_d;
      thr_q       <= thr_d;
      scan_q      <= scan_d;
      best_max_q  <= best_max_d;
      best_time_q <= best_time_d;
      best_freq_q <= best_freq_d;
      m_max_q     <= m_max_d;
      m_time_q    <= m_time_d;
      m_freq_q    <= m_freq_d;
      m_det_q     <= m_det_d;
      reload_q    <= reload_d;
    end
  end

  assign s_axis_freq_step_tready = tready_q;
  assign slice_freq_step         = step_q;
  assign slice_freq_step_valid   = strobe_q;
  assign slice_neg_shift         = neg_q;
  assign slice_run               = run_q;
  assign m_axis_tvalid           = tvalid_q;
  assign m_axis_max              = m_max_q;
  assign m_axis_time_index       = m_time_q;
  assign m_axis_freq_index       = m_freq_q;
  assign m_axis_detect           = m_det_q;

endmodule

// File: tb/tb_caf_foas_ctrl.sv
// Directed testbench for caf_foas_ctrl: load strobes, stalls, tie-break reduction,
// backpressure, rerun without reload, reload request and mid-run reset.
module tb_caf_foas_ctrl;

  localparam int unsigned PB = 10;
  localparam int unsigned NS = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned LW = 3;
  localparam int unsigned MW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_tvalid;
  logic              s_tready;
  logic [PB-1:0]     freq_step;
  logic              neg_shift;
  logic              reload;
  logic [MW-1:0]     threshold;
  logic [PB-1:0]     slice_freq_step;
  logic [NS-1:0]     slice_freq_step_valid;
  logic [NS-1:0]     slice_neg_shift;
  logic              slice_run;
  logic [NS-1:0]     slice_valid;
  logic [NS*MW-1:0]  slice_out_max;
  logic [NS*LW-1:0]  slice_index;
  logic              m_tvalid;
  logic              m_tready;
  logic [MW-1:0]     m_max;
  logic [LW-1:0]     m_time;
  logic [CW-1:0]     m_freq;
  logic              m_detect;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  caf_foas_ctrl #(
    .phase_bits(PB), .foas(NS), .foas_counter_bits(CW),
    .length_counter_bits(LW), .out_max_bits(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_freq_step_tvalid(s_tvalid), .s_axis_freq_step_tready(s_tready),
    .freq_step(freq_step), .neg_shift(neg_shift), .reload(reload), .threshold(threshold),
    .slice_freq_step(slice_freq_step), .slice_freq_step_valid(slice_freq_step_valid),
    .slice_neg_shift(slice_neg_shift), .slice_run(slice_run),
    .slice_valid(slice_valid), .slice_out_max(slice_out_max), .slice_index(slice_index),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_max(m_max),
    .m_axis_time_index(m_time), .m_axis_freq_index(m_freq), .m_axis_detect(m_detect)
  );

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [MW-1:0] mx, input logic [LW-1:0] ix);
    slice_out_max[i*MW +: MW] = mx;
    slice_index[i*LW +: LW]   = ix;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; freq_step = '0; neg_shift = 1'b0; reload = 1'b0;
    threshold = '0; slice_valid = '0; slice_out_max = '0; slice_index = '0; m_tready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({s_tready, slice_freq_step, slice_freq_step_valid, slice_neg_shift, slice_run,
         m_tvalid, m_max, m_time, m_freq, m_detect} !== {1'b1, {(PB+NS+NS+2+MW+LW+CW+1){1'b0}}}) begin
      failures++;
      $display("FAIL reset_outputs tready=%b step=%0d strobe=%b neg=%b run=%b tvalid=%b max=%0d required tready=1 rest=0",
               s_tready, slice_freq_step, slice_freq_step_valid, slice_neg_shift, slice_run, m_tvalid, m_max);
    end
  endtask

  task automatic test_load_b2b();
    logic [PB-1:0] steps [4] = '{10'd10, 10'd20, 10'd30, 10'd40};
    logic          negs  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [NS-1:0] exp_s [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int k = 0; k < 4; k++) begin
      s_tvalid = 1'b1; freq_step = steps[k]; neg_shift = negs[k];
      tick();
      checks++;
      if (slice_freq_step_valid !== exp_s[k] || slice_freq_step !== steps[k]) begin
        failures++;
        $display("FAIL load_beat%0d strobe=%b step=%0d required strobe=%b step=%0d",
                 k, slice_freq_step_valid, slice_freq_step, exp_s[k], steps[k]);
      end
    end
    checks++;
    if (slice_neg_shift !== 4'b1010 || s_tready !== 1'b0 || slice_run !== 1'b1) begin
      failures++;
      $display("FAIL load_done neg=%b tready=%b run=%b required neg=1010 tready=0 run=1",
               slice_neg_shift, s_tready, slice_run);
    end
    // A beat offered in CORRELATE must be ignored.
    s_tvalid = 1'b1; freq_step = 10'd99; neg_shift = 1'b0;
    tick();
    s_tvalid = 1'b0;
    checks++;
    if (slice_freq_step_valid !== 4'b0000 || slice_freq_step !== 10'd40 || slice_neg_shift !== 4'b1010) begin
      failures++;
      $display("FAIL beat_in_correlate strobe=%b step=%0d neg=%b required 0000/40/1010",
               slice_freq_step_valid, slice_freq_step, slice_neg_shift);
    end
  endtask

  task automatic test_reduce_tie();
    int n;
    threshold = 16'd400;
    put(0, 16'd100, 3'd1); put(1, 16'd500, 3'd2); put(2, 16'd500, 3'd5); put(3, 16'd200, 3'd7);
    slice_valid = 4'b1000; tick();
    // Slice 3 stays valid with a huge peak; its first capture must stand.
    put(3, 16'hFFFF, 3'd0);
    slice_valid = 4'b1001; tick();
    slice_valid = 4'b0100; tick();
    slice_valid = 4'b0010; tick();
    slice_valid = 4'b0000;
    n = 0;
    while (m_tvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 5) begin
      failures++;
      $display("FAIL tvalid_latency cycles=%0d required=5", n);
    end
    checks++;
    if (m_max !== 16'd500 || m_time !== 3'd2 || m_freq !== 2'd1 || m_detect !== 1'b1) begin
      failures++;
      $display("FAIL tie_result max=%0d time=%0d freq=%0d det=%b required 500/2/1/1",
               m_max, m_time, m_freq, m_detect);
    end
  endtask

  task automatic test_backpressure_rerun();
    m_tready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (m_tvalid !== 1'b1 || m_max !== 16'd500 || m_time !== 3'd2 || m_freq !== 2'd1 || m_detect !== 1'b1) begin
        failures++;
        $display("FAIL hold_cycle%0d tvalid=%b max=%0d time=%0d freq=%0d det=%b required 1/500/2/1/1",
                 c, m_tvalid, m_max, m_time, m_freq, m_detect);
      end
    end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    checks++;
    if (m_tvalid !== 1'b0 || slice_run !== 1'b1 || s_tready !== 1'b0 || slice_freq_step_valid !== 4'b0000) begin
      failures++;
      $display("FAIL rerun_entry tvalid=%b run=%b tready=%b strobe=%b required 0/1/0/0000",
               m_tvalid, slice_run, s_tready, slice_freq_step_valid);
    end
  endtask

  task automatic test_reload_threshold();
    int n;
    threshold = 16'd600;
    put(0, 16'd300, 3'd3); put(1, 16'd50, 3'd4); put(2, 16'd550, 3'd6); put(3, 16'd550, 3'd0);
    slice_valid = 4'b1111; tick();
    slice_valid = 4'b0000; tick();
    // Now in FIND_MAX: request a reload and move the threshold after it was sampled.
    reload = 1'b1; tick();
    reload = 1'b0; threshold = 16'd0;
    n = 0;
    while (m_tvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (m_tvalid !== 1'b1 || m_max !== 16'd550 || m_time !== 3'd6 || m_freq !== 2'd2 || m_detect !== 1'b0) begin
      failures++;
      $display("FAIL rerun_result tvalid=%b max=%0d time=%0d freq=%0d det=%b required 1/550/6/2/0",
               m_tvalid, m_max, m_time, m_freq, m_detect);
    end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || slice_run !== 1'b0) begin
      failures++;
      $display("FAIL reload_to_load tvalid=%b tready=%b run=%b required 0/1/0", m_tvalid, s_tready, slice_run);
    end
  endtask

  task automatic test_load_stall();
    s_tvalid = 1'b1; freq_step = 10'd11; neg_shift = 1'b1; tick();
    checks++;
    if (slice_freq_step_valid !== 4'b0001 || slice_neg_shift !== 4'b1011) begin
      failures++;
      $display("FAIL stall_beat0 strobe=%b neg=%b required 0001/1011", slice_freq_step_valid, slice_neg_shift);
    end
    freq_step = 10'd22; tick();
    s_tvalid = 1'b0;
    checks++;
    if (slice_freq_step_valid !== 4'b0010 || slice_freq_step !== 10'd22) begin
      failures++;
      $display("FAIL stall_beat1 strobe=%b step=%0d required 0010/22", slice_freq_step_valid, slice_freq_step);
    end
    for (int g = 0; g < 3; g++) begin
      tick();
      checks++;
      if (slice_freq_step_valid !== 4'b0000 || s_tready !== 1'b1 || slice_freq_step !== 10'd22) begin
        failures++;
        $display("FAIL stall_gap%0d strobe=%b tready=%b step=%0d required 0000/1/22",
                 g, slice_freq_step_valid, s_tready, slice_freq_step);
      end
    end
    s_tvalid = 1'b1; freq_step = 10'd33; neg_shift = 1'b0; tick();
    checks++;
    if (slice_freq_step_valid !== 4'b0100 || slice_freq_step !== 10'd33) begin
      failures++;
      $display("FAIL stall_resume strobe=%b step=%0d required 0100/33", slice_freq_step_valid, slice_freq_step);
    end
    freq_step = 10'd44; tick();
    s_tvalid = 1'b0;
    checks++;
    if (slice_freq_step_valid !== 4'b1000 || slice_neg_shift !== 4'b0011 || s_tready !== 1'b0 || slice_run !== 1'b1) begin
      failures++;
      $display("FAIL stall_done strobe=%b neg=%b tready=%b run=%b required 1000/0011/0/1",
               slice_freq_step_valid, slice_neg_shift, s_tready, slice_run);
    end
  endtask

  task automatic test_mid_reset();
    put(0, 16'd77, 3'd1);
    slice_valid = 4'b0001; tick();
    rst = 1'b1; s_tvalid = 1'b1; freq_step = 10'd5; reload = 1'b1;
    tick();
    rst = 1'b0; reload = 1'b0; slice_valid = 4'b0000;
    checks++;
    if ({s_tready, slice_freq_step, slice_freq_step_valid, slice_neg_shift, slice_run,
         m_tvalid, m_max, m_time, m_freq, m_detect} !== {1'b1, {(PB+NS+NS+2+MW+LW+CW+1){1'b0}}}) begin
      failures++;
      $display("FAIL mid_reset tready=%b step=%0d strobe=%b neg=%b run=%b tvalid=%b required tready=1 rest=0",
               s_tready, slice_freq_step, slice_freq_step_valid, slice_neg_shift, slice_run, m_tvalid);
    end
    tick();
    s_tvalid = 1'b0;
    checks++;
    if (slice_freq_step_valid !== 4'b0001 || slice_freq_step !== 10'd5) begin
      failures++;
      $display("FAIL post_reset_load strobe=%b step=%0d required 0001/5", slice_freq_step_valid, slice_freq_step);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_b2b();
    test_reduce_tie();
    test_backpressure_rerun();
    test_reload_threshold();
    test_load_stall();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
